transposer_word_feeder: RTL

//  Store-and-forward word buffer directly upstream of data_transposer.

---
 rtl/transposer_word_feeder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/transposer_word_feeder.sv
// Purpose : store-and-forward word buffer that queues host words and streams one job's worth to data_transposer.
// Latency : first word is on tp_iword one cycle after the FIFO holds the job's word count; tp_iword is combinational from the FIFO head.
// Backpr. : tp_busy=1 holds the FIFO head (tp_iword=0); pushes while host_full=1 are dropped and flagged on err_ovf.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   host_wr_en/host_wr_data         host push into the FIFO; host_full when DEPTH words are resident
//   cfg_prec/cfg_baddr/cfg_nwords   job configuration, captured on an accepted cfg_go
//   cfg_go                          launch pulse, acted on only while idle
//   job_busy/job_done/err_ovf       job status; err_ovf is sticky until the next accepted cfg_go
//   tp_prec/tp_baddr/tp_iword/tp_start/tp_busy   data_transposer side
// Build option: FEEDER_STALL_CNT_EN adds stall_cnt[31:0] (busy cycles seen while streaming/draining).
module transposer_word_feeder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  parameter int CNTW  = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            host_wr_en,
  input  logic [XLEN-1:0] host_wr_data,
  output logic            host_full,
  input  logic [31:0]     cfg_prec,
  input  logic [31:0]     cfg_baddr,
  input  logic [CNTW-1:0] cfg_nwords,
  input  logic            cfg_go,
  output logic            job_busy,
  output logic            job_done,
  output logic            err_ovf,
  output logic [31:0]     tp_prec,
  output logic [31:0]     tp_baddr,
  output logic [XLEN-1:0] tp_iword,
  output logic            tp_start,
  input  logic            tp_busy
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;

  logic [CNTW-1:0] nwords_q, nwords_d;
  logic [CNTW-1:0] sent_q, sent_d;
  logic [31:0]     prec_q, prec_d;
  logic [31:0]     baddr_q, baddr_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic            push, push_drop, pop, cfg_ok, go_accept;
  logic [CNTW:0]   fill_avail;

  assign host_full  = (count_q == DEPTH_C);
  assign push       = host_wr_en && !host_full;
  assign push_drop  = host_wr_en && host_full;
  // Pop only while streaming and the transposer is ready; count guard is belt and braces.
  assign pop        = (state_q == ST_STREAM) && !tp_busy && (count_q != '0);
  assign cfg_ok     = (cfg_nwords != '0) && (cfg_nwords <= DEPTH_C);
  assign go_accept  = (state_q == ST_IDLE) && cfg_go && cfg_ok;
  // A word pushed this cycle counts toward the fill threshold.
  assign fill_avail = {1'b0, count_q} + {{CNTW{1'b0}}, push};

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    sent_d   = sent_q;
    prec_d   = prec_q;
    baddr_d  = baddr_q;
    start_d  = start_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_go) begin
          if (cfg_ok) begin
            prec_d   = cfg_prec;
            baddr_d  = cfg_baddr;
            nwords_d = cfg_nwords;
            sent_d   = '0;
            ovf_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = ST_FILL;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (fill_avail >= {1'b0, nwords_q}) begin
          start_d = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop) begin
          sent_d = sent_q + CNTW'(1);
          if (sent_q + CNTW'(1) == nwords_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!tp_busy) begin
          start_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A dropped push flags the error even in the cycle a job is accepted.
    if (push_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      nwords_q <= '0;
      sent_q   <= '0;
      prec_q   <= '0;
      baddr_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      sent_q   <= sent_d;
      prec_q   <= prec_d;
      baddr_q  <= baddr_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage needs no reset: emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= host_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (go_accept) begin
      stall_q <= '0;
    end else if ((state_q == ST_STREAM || state_q == ST_DRAIN) && tp_busy && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cnt = stall_q;
`else
  logic unused_go;
  assign unused_go = go_accept;
`endif

  assign tp_iword = pop ? mem[rd_ptr_q] : '0;
  assign tp_start = start_q;
  assign job_busy = busy_q;
  assign job_done = done_q;
  assign err_ovf  = ovf_q;
  assign tp_prec  = prec_q;
  assign tp_baddr = baddr_q;

endmodule
